// File: rtl/ip_tx_tile_pkg.sv
// Shared types and constants for the IP TX tile: the noc0 header flit layout,
// the NoC-input FSM states and the UDP-TX message type agreed with the UDP TX tile.
package ip_tx_tile_pkg;

  localparam int NOC_DATA_WIDTH  = 512;
  localparam int MAC_INTERFACE_W = NOC_DATA_WIDTH;
  localparam int NOC_BYTES       = NOC_DATA_WIDTH / 8;
  localparam int MAC_PADBYTES_W  = $clog2(NOC_BYTES);
  localparam int IP_ADDR_W       = 32;
  localparam int TOT_LEN_W       = 16;
  localparam int PROTOCOL_W      = 8;
  localparam int MSG_TIMESTAMP_W = 64;
  localparam int MSG_LEN_W       = 8;
  localparam int XY_W            = 8;
  localparam int MSG_TYPE_W      = 8;

  localparam logic [MSG_TYPE_W-1:0] UDP_TX_MSG_TYPE = 8'h0b;

  localparam int HDR_USED_W = 4 * XY_W + MSG_LEN_W + MSG_TYPE_W + 2 * IP_ADDR_W
                            + TOT_LEN_W + PROTOCOL_W + MSG_TIMESTAMP_W;

  typedef struct packed {
    logic [XY_W-1:0]                    dst_x;
    logic [XY_W-1:0]                    dst_y;
    logic [MSG_LEN_W-1:0]               msg_len;
    logic [XY_W-1:0]                    src_x;
    logic [XY_W-1:0]                    src_y;
    logic [MSG_TYPE_W-1:0]              msg_type;
    logic [IP_ADDR_W-1:0]               src_ip;
    logic [IP_ADDR_W-1:0]               dst_ip;
    logic [TOT_LEN_W-1:0]               data_len;
    logic [PROTOCOL_W-1:0]              protocol;
    logic [MSG_TIMESTAMP_W-1:0]         timestamp;
    logic [NOC_DATA_WIDTH-HDR_USED_W-1:0] rsvd;
  } ip_tx_noc_hdr_flit;

  typedef enum logic [1:0] {
    RX_HDR   = 2'd0,
    HDR_OUT  = 2'd1,
    DATA_OUT = 2'd2
  } ip_tx_noc_in_state_e;

endpackage

// File: rtl/ip_tx_noc_in_ctrl.sv
// Message-level FSM and payload flit counter; owns every handshake on the
// NoC, header and payload interfaces.
module ip_tx_noc_in_ctrl
  import ip_tx_tile_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_noc_val,
  input  logic                 i_hdr_rdy,
  input  logic                 i_data_rdy,
  input  logic                 i_last,
  input  logic [MSG_LEN_W-1:0] i_msg_len,
  output logic                 o_noc_rdy,
  output logic                 o_hdr_val,
  output logic                 o_data_val,
  output logic                 o_hdr_load,
  output logic                 o_in_data,
  output logic [MSG_LEN_W-1:0] o_cnt
);

  ip_tx_noc_in_state_e r_state, w_state_nxt;
  logic [MSG_LEN_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= RX_HDR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (o_hdr_load)
        r_cnt <= i_msg_len;
      else if (o_data_val && i_data_rdy)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_noc_rdy   = 1'b0;
    o_hdr_val   = 1'b0;
    o_data_val  = 1'b0;
    o_hdr_load  = 1'b0;
    o_in_data   = 1'b0;
    case (r_state)
      RX_HDR: begin
        o_noc_rdy = 1'b1;
        if (i_noc_val) begin
          o_hdr_load  = 1'b1;
          w_state_nxt = HDR_OUT;
        end
      end
      HDR_OUT: begin
        o_hdr_val = 1'b1;
        if (i_hdr_rdy)
          w_state_nxt = (r_cnt == '0) ? RX_HDR : DATA_OUT;
      end
      DATA_OUT: begin
        // Payload bypasses storage entirely: the NoC sees the assembler's ready.
        o_in_data  = 1'b1;
        o_data_val = i_noc_val;
        o_noc_rdy  = i_data_rdy;
        if (i_noc_val && i_data_rdy && i_last)
          w_state_nxt = RX_HDR;
      end
      default: w_state_nxt = RX_HDR;
    endcase
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/ip_tx_noc_in_datap.sv
// Header-field capture, trailing-pad computation and last-beat detection;
// also checks header flit sanity in simulation.
module ip_tx_noc_in_datap
  import ip_tx_tile_pkg::*;
#(
  parameter int TILE_X = -1,
  parameter int TILE_Y = -1
) (
  input  logic                       i_clk,
  input  logic [NOC_DATA_WIDTH-1:0]  i_flit,
  input  logic                       i_load,
  input  logic                       i_in_data,
  input  logic [MSG_LEN_W-1:0]       i_cnt,
  output logic [MSG_LEN_W-1:0]       o_msg_len,
  output logic [IP_ADDR_W-1:0]       o_src_ip,
  output logic [IP_ADDR_W-1:0]       o_dst_ip,
  output logic [TOT_LEN_W-1:0]       o_data_len,
  output logic [PROTOCOL_W-1:0]      o_protocol,
  output logic [MSG_TIMESTAMP_W-1:0] o_timestamp,
  output logic                       o_last,
  output logic [MAC_PADBYTES_W-1:0]  o_padbytes
);

  ip_tx_noc_hdr_flit w_hdr;
  logic [MAC_PADBYTES_W-1:0] r_pad;

  assign w_hdr     = ip_tx_noc_hdr_flit'(i_flit);
  assign o_msg_len = w_hdr.msg_len;

  always_ff @(posedge i_clk) begin
    if (i_load) begin
      o_src_ip    <= w_hdr.src_ip;
      o_dst_ip    <= w_hdr.dst_ip;
      o_data_len  <= w_hdr.data_len;
      o_protocol  <= w_hdr.protocol;
      o_timestamp <= w_hdr.timestamp;
      // Bytes short of a whole flit, modulo the flit size.
      r_pad       <= MAC_PADBYTES_W'(-w_hdr.data_len);

      assert (32'(w_hdr.msg_len) == (32'(w_hdr.data_len) + NOC_BYTES - 1) / NOC_BYTES)
        else $error("ip_tx_noc_in: msg_len %0d inconsistent with data_len %0d",
                    w_hdr.msg_len, w_hdr.data_len);
      assert ((TILE_X < 0 || w_hdr.dst_x == XY_W'(TILE_X)) &&
              (TILE_Y < 0 || w_hdr.dst_y == XY_W'(TILE_Y)))
        else $error("ip_tx_noc_in: misrouted flit for (%0d,%0d)", w_hdr.dst_x, w_hdr.dst_y);
      assert (w_hdr.msg_type == UDP_TX_MSG_TYPE && w_hdr.rsvd == '0)
        else $error("ip_tx_noc_in: bad header type %0h from (%0d,%0d)",
                    w_hdr.msg_type, w_hdr.src_x, w_hdr.src_y);
    end
  end

  assign o_last     = i_in_data && (i_cnt == MSG_LEN_W'(1));
  assign o_padbytes = o_last ? r_pad : '0;

endmodule

// File: rtl/ip_tx_noc_in.sv
// noc0 receive endpoint of the IP TX tile: splits each UDP-TX message into a
// header handshake and a zero-latency MAC-width payload stream.
module ip_tx_noc_in
  import ip_tx_tile_pkg::*;
#(
  parameter int TILE_X = -1,
  parameter int TILE_Y = -1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       noc0_ctovr_ip_tx_in_val,
  input  logic [NOC_DATA_WIDTH-1:0]  noc0_ctovr_ip_tx_in_data,
  output logic                       ip_tx_in_noc0_ctovr_rdy,
  output logic                       ip_tx_in_assemble_hdr_val,
  output logic [IP_ADDR_W-1:0]       ip_tx_in_assemble_src_ip,
  output logic [IP_ADDR_W-1:0]       ip_tx_in_assemble_dst_ip,
  output logic [TOT_LEN_W-1:0]       ip_tx_in_assemble_data_len,
  output logic [PROTOCOL_W-1:0]      ip_tx_in_assemble_protocol,
  output logic [MSG_TIMESTAMP_W-1:0] ip_tx_in_assemble_timestamp,
  input  logic                       assemble_ip_tx_in_hdr_rdy,
  output logic                       ip_tx_in_assemble_data_val,
  output logic [MAC_INTERFACE_W-1:0] ip_tx_in_assemble_data,
  output logic                       ip_tx_in_assemble_data_last,
  output logic [MAC_PADBYTES_W-1:0]  ip_tx_in_assemble_data_padbytes,
  input  logic                       assemble_ip_tx_in_data_rdy
);

  logic                 w_hdr_load;
  logic                 w_in_data;
  logic                 w_last;
  logic [MSG_LEN_W-1:0] w_cnt;
  logic [MSG_LEN_W-1:0] w_msg_len;

  ip_tx_noc_in_ctrl u_ctrl (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_noc_val  (noc0_ctovr_ip_tx_in_val),
    .i_hdr_rdy  (assemble_ip_tx_in_hdr_rdy),
    .i_data_rdy (assemble_ip_tx_in_data_rdy),
    .i_last     (w_last),
    .i_msg_len  (w_msg_len),
    .o_noc_rdy  (ip_tx_in_noc0_ctovr_rdy),
    .o_hdr_val  (ip_tx_in_assemble_hdr_val),
    .o_data_val (ip_tx_in_assemble_data_val),
    .o_hdr_load (w_hdr_load),
    .o_in_data  (w_in_data),
    .o_cnt      (w_cnt)
  );

  ip_tx_noc_in_datap #(
    .TILE_X (TILE_X),
    .TILE_Y (TILE_Y)
  ) u_datap (
    .i_clk       (clk),
    .i_flit      (noc0_ctovr_ip_tx_in_data),
    .i_load      (w_hdr_load),
    .i_in_data   (w_in_data),
    .i_cnt       (w_cnt),
    .o_msg_len   (w_msg_len),
    .o_src_ip    (ip_tx_in_assemble_src_ip),
    .o_dst_ip    (ip_tx_in_assemble_dst_ip),
    .o_data_len  (ip_tx_in_assemble_data_len),
    .o_protocol  (ip_tx_in_assemble_protocol),
    .o_timestamp (ip_tx_in_assemble_timestamp),
    .o_last      (w_last),
    .o_padbytes  (ip_tx_in_assemble_data_padbytes)
  );

  assign ip_tx_in_assemble_data      = noc0_ctovr_ip_tx_in_data;
  assign ip_tx_in_assemble_data_last = w_last;

endmodule
